reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Power-on and soft-reset controller for the game board. Holds every subsystem reset for a fixed power-on interval (10 s at 50 MHz by default), then releases per-subsystem resets one stage at a time: display, then input, then game logic. After that it arbitrates soft-reset requests from several requesters (restart button, game-over logic) with a req/ack handshake and re-runs the staged release without repeating the long hold. It sits between the board clock/reset and all game-logic blocks.

Parameters:
NUM_STAGES, 3, number of independently released reset outputs (>=1)
NUM_REQ, 2, number of soft-reset requesters (>=1)
HOLD_CYCLES, 500000000, power-on hold length in clock cycles (>=1)
STAGE_GAP, 1000, cycles between successive stage releases (>=1)
SOFT_CYCLES, 16, cycles all resets are held during a soft reset (>=1)
CNT_W, 30, counter width; must hold max(HOLD_CYCLES, STAGE_GAP, SOFT_CYCLES)

Ports:
clock  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
req  input  NUM_REQ  soft-reset request per requester; level, held until acked
ack  output  NUM_REQ  one-cycle grant pulse, one-hot
rst_out  output  NUM_STAGES  active-high reset per subsystem stage
ready  output  1  high only when all stages are released (RUN state)

Behaviour:
- Reset (reset_n low at an edge): state=HOLD, count=0, stage=0, rst_out=all 1, ready=0, ack=0. This applies from any state, including mid-RELEASE and mid-SOFT. The full HOLD period always restarts.
- Edge numbering: edge 1 is the first rising edge with reset_n high.
- HOLD: count increments each edge. At the edge where count==HOLD_CYCLES-1 (edge HOLD_CYCLES), rst_out[0] goes 0, count goes to 0, stage goes to 1, and the state moves to RELEASE.
- RELEASE: count increments each edge. At each edge where count==STAGE_GAP-1, rst_out[stage] goes 0, stage increments and count goes to 0.
- Reaching RUN: the edge that releases stage NUM_STAGES-1 also enters RUN and sets ready=1.
- NUM_STAGES=1: HOLD goes directly to RUN. rst_out[0] falls and ready rises on the same edge.
- Release order: stages are released strictly in index order and are never re-asserted individually.
- RUN: req is sampled every edge. If any req bit is set, fixed priority selects the lowest index i. On that edge: ack[i]=1 for exactly one cycle, state=SOFT, rst_out=all 1, ready=0, count=0.
- Requests outside RUN: in HOLD, RELEASE and SOFT, req is ignored and ack stays 0. Requesters keep req high until acked.
- SOFT: count increments each edge. At the edge where count==SOFT_CYCLES-1, rst_out[0] goes 0, stage goes to 1 and the state moves to RELEASE. HOLD is skipped.
- Req held after ack: it is treated as a new request on the first RUN edge. The earliest such edge is the cycle after ready rises.
- Counter: never wraps in normal operation. All comparisons are equality against parameter-1.
- Outputs: all outputs are registered, with no combinational path from req to ack.

Optional Feature:
RESET_SEQ_CAUSE_EN
- With the macro defined: an extra output port cause [NUM_REQ:0], registered and one-hot.
  - bit0 = power-on/reset_n reset; bit i+1 = soft reset granted to requester i.
  - Set to 1 (bit0) by reset_n low. Loaded on the same edge that asserts ack.
  - Holds its value until the next reset event.
- Without the macro: the port and its register are absent, and all other behaviour is identical.

Test Plan:
(Parameters: HOLD_CYCLES=8, STAGE_GAP=2, SOFT_CYCLES=4, NUM_STAGES=3, NUM_REQ=2)
- Power-up: reset_n low 3 cycles, then high -> rst_out=111 through edge 7; 110 at edge 8; 100 at edge 10; 000 and ready=1 at edge 12.
- req[0]=1 from edge 2, held -> ack stays 00 until edge 13. ack=01 at edge 13 only; rst_out=111 and ready=0 at edge 13; rst_out[0] falls at edge 17; ready=1 at edge 21.
- req=11 in RUN, both held -> ack=01 first. After the re-release completes, ack=10 on the edge after ready rises. ack is never 11.
- reset_n low for 1 cycle during RELEASE (rst_out=110) -> rst_out=111 and ready=0 at that edge; rst_out[0] falls exactly 8 edges after reset_n returns high.
- RESET_SEQ_CAUSE_EN defined -> cause=001 after power-up; cause=100 on the edge ack=10 is issued; cause=001 again after reset_n pulse.
- NUM_STAGES=1, HOLD_CYCLES=4 -> rst_out=0 and ready=1 both at edge 4.

Source files
------------

// File: rtl/reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : reset_sequencer                                                |
// | Purpose : power-on hold, staged per-subsystem reset release and          |
// |           arbitrated soft reset with a req/ack handshake.                |
// | Option  : define RESET_SEQ_CAUSE_EN to add the one-hot 'cause' output.   |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 500000000,
  parameter int STAGE_GAP   = 1000,
  parameter int SOFT_CYCLES = 16,
  parameter int CNT_W       = 30
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready
`ifdef RESET_SEQ_CAUSE_EN
  ,
  output logic [NUM_REQ:0]      cause
`endif
);

  localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_CYCLES - 1);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_SOFT    = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        count_q;
  logic [STG_W-1:0]        stage_q;
  logic [NUM_REQ-1:0]      ack_q;
  logic [NUM_STAGES-1:0]   rst_out_q;
  logic                    ready_q;
  logic [NUM_REQ-1:0]      grant_d;
`ifdef RESET_SEQ_CAUSE_EN
  logic [NUM_REQ:0]        cause_q;
`endif

  // Fixed priority: the lowest-index requester wins.
  always_comb begin
    grant_d = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) grant_d = NUM_REQ'(1) << i;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_HOLD;
      count_q   <= '0;
      stage_q   <= '0;
      ack_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
`ifdef RESET_SEQ_CAUSE_EN
      cause_q   <= (NUM_REQ + 1)'(1);
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        S_HOLD, S_SOFT: begin
          if ((state_q == S_HOLD && count_q == HOLD_LAST) ||
              (state_q == S_SOFT && count_q == SOFT_LAST)) begin
            count_q      <= '0;
            rst_out_q[0] <= 1'b0;
            if (NUM_STAGES == 1) begin
              state_q <= S_RUN;
              ready_q <= 1'b1;
            end else begin
              stage_q <= STG_W'(1);
              state_q <= S_RELEASE;
            end
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (count_q == GAP_LAST) begin
            count_q   <= '0;
            rst_out_q <= rst_out_q & ~(NUM_STAGES'(1) << stage_q);
            stage_q   <= stage_q + STG_W'(1);
            if (stage_q == LAST_STAGE) begin
              state_q <= S_RUN;
              ready_q <= 1'b1;
            end
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (|req) begin
            ack_q     <= grant_d;
            state_q   <= S_SOFT;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            count_q   <= '0;
            stage_q   <= '0;
`ifdef RESET_SEQ_CAUSE_EN
            cause_q   <= {grant_d, 1'b0};
`endif
          end
        end
        default: begin
          state_q <= S_HOLD;
          count_q <= '0;
        end
      endcase
    end
  end

  assign ack     = ack_q;
  assign rst_out = rst_out_q;
  assign ready   = ready_q;
`ifdef RESET_SEQ_CAUSE_EN
  assign cause   = cause_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_reset_sequencer                                             |
// | Purpose : scoreboard bench for reset_sequencer (3-stage and 1-stage).    |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_reset_sequencer;

  typedef struct {
    int         en;
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] ack;
    logic [2:0] cause;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [1:0] req0;
  logic [1:0] req1;
  logic [1:0] ack0, ack1;
  logic [2:0] rst_out0;
  logic [0:0] rst_out1;
  logic       ready0, ready1;
  logic [2:0] cause0, cause1;

  exp_t q0[$];
  exp_t q1[$];
  int   edge_n;
  int   n_cmp;
  int   n_bad;

  reset_sequencer #(
    .NUM_STAGES(3), .NUM_REQ(2), .HOLD_CYCLES(8), .STAGE_GAP(2),
    .SOFT_CYCLES(4), .CNT_W(8)
  ) dut0 (
    .clock(clk), .reset_n(reset_n), .req(req0), .ack(ack0),
    .rst_out(rst_out0), .ready(ready0)
`ifdef RESET_SEQ_CAUSE_EN
    , .cause(cause0)
`endif
  );

  reset_sequencer #(
    .NUM_STAGES(1), .NUM_REQ(2), .HOLD_CYCLES(4), .STAGE_GAP(2),
    .SOFT_CYCLES(4), .CNT_W(8)
  ) dut1 (
    .clock(clk), .reset_n(reset_n), .req(req1), .ack(ack1),
    .rst_out(rst_out1), .ready(ready1)
`ifdef RESET_SEQ_CAUSE_EN
    , .cause(cause1)
`endif
  );

`ifndef RESET_SEQ_CAUSE_EN
  assign cause0 = 3'b000;
  assign cause1 = 3'b000;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge numbering restarts at every edge that samples reset_n low.
  always @(posedge clk) edge_n <= reset_n ? edge_n + 1 : 0;

  task automatic push0(input int en, input logic [2:0] rst, input logic rdy,
                       input logic [1:0] ack, input logic [2:0] cause);
    exp_t e;
    e.en = en; e.rst = rst; e.rdy = rdy; e.ack = ack; e.cause = cause;
    q0.push_back(e);
  endtask

  task automatic push1(input int en, input logic rst, input logic rdy);
    exp_t e;
    e.en = en; e.rst = {2'b00, rst}; e.rdy = rdy; e.ack = 2'b00; e.cause = 3'b001;
    q1.push_back(e);
  endtask

  function automatic bit differs(exp_t w, int en, logic [2:0] rst, logic rdy,
                                 logic [1:0] ack, logic [2:0] cause);
    bit d;
    d = (en != w.en) || (rst !== w.rst) || (rdy !== w.rdy) || (ack !== w.ack);
`ifdef RESET_SEQ_CAUSE_EN
    d = d || (cause !== w.cause);
`endif
    return d;
  endfunction

  // Monitors: every change of a DUT's outputs is one presented response.
  logic [8:0] prev0, prev1, obs0, obs1;
  initial begin prev0 = 'x; prev1 = 'x; end

  always @(negedge clk) begin
    exp_t w;
    obs0 = {rst_out0, ready0, ack0, cause0};
    if (obs0 !== prev0) begin
      prev0 = obs0;
      n_cmp++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL dut0 unexpected change at edge %0d: rst=%b rdy=%b ack=%b",
                 edge_n, rst_out0, ready0, ack0);
      end else begin
        w = q0.pop_front();
        if (differs(w, edge_n, rst_out0, ready0, ack0, cause0)) begin
          n_bad++;
          $display("FAIL dut0 event: got edge=%0d rst=%b rdy=%b ack=%b cause=%b, want edge=%0d rst=%b rdy=%b ack=%b cause=%b",
                   edge_n, rst_out0, ready0, ack0, cause0, w.en, w.rst, w.rdy, w.ack, w.cause);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t w;
    obs1 = {2'b00, rst_out1, ready1, ack1, cause1};
    if (obs1 !== prev1) begin
      prev1 = obs1;
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL dut1 unexpected change at edge %0d: rst=%b rdy=%b ack=%b",
                 edge_n, rst_out1, ready1, ack1);
      end else begin
        w = q1.pop_front();
        if (differs(w, edge_n, {2'b00, rst_out1}, ready1, ack1, cause1)) begin
          n_bad++;
          $display("FAIL dut1 event: got edge=%0d rst=%b rdy=%b ack=%b cause=%b, want edge=%0d rst=%b rdy=%b ack=%b cause=%b",
                   edge_n, rst_out1, ready1, ack1, cause1, w.en, w.rst[0], w.rdy, w.ack, w.cause);
        end
      end
    end
  end

  task automatic wait_edge(input int n);
    int guard = 0;
    while (edge_n < n && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout waiting for edge %0d: got edge %0d", n, edge_n);
    end
  endtask

  task automatic wait_ack(input int idx);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!ack0[idx] && guard < 100);
    if (!ack0[idx]) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout waiting for ack[%0d]: got ack=%b", idx, ack0);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; edge_n = 0;
    reset_n = 1'b0; req0 = 2'b00; req1 = 2'b00;

    // Power-up, then requester 0 asserting early and waiting for RUN.
    push0(0,  3'b111, 1'b0, 2'b00, 3'b001);
    push0(8,  3'b110, 1'b0, 2'b00, 3'b001);
    push0(10, 3'b100, 1'b0, 2'b00, 3'b001);
    push0(12, 3'b000, 1'b1, 2'b00, 3'b001);
    push0(13, 3'b111, 1'b0, 2'b01, 3'b010);
    push0(14, 3'b111, 1'b0, 2'b00, 3'b010);
    push0(17, 3'b110, 1'b0, 2'b00, 3'b010);
    push0(19, 3'b100, 1'b0, 2'b00, 3'b010);
    push0(21, 3'b000, 1'b1, 2'b00, 3'b010);
    push1(0, 1'b1, 1'b0);
    push1(4, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_edge(1);
    req0 = 2'b01;
    wait_ack(0);
    req0 = 2'b00;

    // Both requesters at once: 0 wins, 1 is served right after ready rises.
    wait_edge(21);
    push0(22, 3'b111, 1'b0, 2'b01, 3'b010);
    push0(23, 3'b111, 1'b0, 2'b00, 3'b010);
    push0(26, 3'b110, 1'b0, 2'b00, 3'b010);
    push0(28, 3'b100, 1'b0, 2'b00, 3'b010);
    push0(30, 3'b000, 1'b1, 2'b00, 3'b010);
    push0(31, 3'b111, 1'b0, 2'b10, 3'b100);
    push0(32, 3'b111, 1'b0, 2'b00, 3'b100);
    push0(35, 3'b110, 1'b0, 2'b00, 3'b100);
    req0 = 2'b11;
    wait_ack(0);
    req0 = 2'b10;
    wait_ack(1);
    req0 = 2'b00;

    // One-cycle reset_n pulse mid-RELEASE restarts the full hold.
    wait_edge(35);
    push0(0,  3'b111, 1'b0, 2'b00, 3'b001);
    push0(8,  3'b110, 1'b0, 2'b00, 3'b001);
    push0(10, 3'b100, 1'b0, 2'b00, 3'b001);
    push0(12, 3'b000, 1'b1, 2'b00, 3'b001);
    push1(0, 1'b1, 1'b0);
    push1(4, 1'b0, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_edge(14);
    @(negedge clk);

    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL leftover expectations: got dut0=%0d dut1=%0d pending, want 0",
               q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
